// File: rtl/datapath_sequencer_pkg.sv
// Shared constants and state encoding for the datapath program sequencer.
package datapath_sequencer_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned FLAG_W    = 5;
    localparam int unsigned CARRY_BIT = 3;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    // Halt word; doubles as the idle opCode seen by the datapath.
    localparam logic [INSTR_W-1:0] HALT_CODE = 16'h0000;

    // Last ROM address; the program counter never wraps past it.
    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_LATCH  = 3'd4,
        ST_PAUSE  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Sequencer <-> instruction ROM / datapath signal bundle.
interface datapath_sequencer_if
    import datapath_sequencer_pkg::*;
;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] op_code;
    logic [FLAG_W-1:0]  dp_flags;
    logic               cin;

    // Sequencer side
    modport master (
        output imem_addr,
        output op_code,
        output cin,
        input  imem_data,
        input  dp_flags
    );

    // ROM / datapath side
    modport slave (
        input  imem_addr,
        input  op_code,
        input  cin,
        output imem_data,
        output dp_flags
    );

endinterface

// File: rtl/datapath_sequencer.sv
// Program sequencer: fetches words from a synchronous ROM, issues each one to
// the datapath opCode for a single cycle, and latches the resulting flags.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step_en,
    input  logic                  step,
    datapath_sequencer_if.master  bus,
    output logic [FLAG_W-1:0]     flags_q,
    output logic [ADDR_W-1:0]     pc,
    output logic [CNT_W-1:0]      instr_cnt,
    output logic                  busy,
    output logic                  done
);

    state_t               state;
    state_t               state_d;
    logic [ADDR_W-1:0]    pc_d;
    logic [CNT_W-1:0]     cnt_d;
    logic [INSTR_W-1:0]   op_q;
    logic [INSTR_W-1:0]   op_d;
    logic [FLAG_W-1:0]    flags_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 step_q;
    logic                 step_rise;

    // ROM is addressed straight from the program counter.
    assign bus.imem_addr = pc;
    assign bus.op_code   = op_q;
    assign bus.cin       = flags_q[CARRY_BIT];

    assign step_rise = step & ~step_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath-register next values.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        cnt_d   = instr_cnt;
        op_d    = op_q;
        flags_d = flags_q;

        case (state)
            ST_IDLE, ST_DONE: begin
                op_d = HALT_CODE;
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    flags_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (bus.imem_data == HALT_CODE) begin
                    state_d = ST_DONE;
                end else begin
                    op_d    = bus.imem_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Datapath executes on this closing edge; drop back to idle opCode.
                op_d    = HALT_CODE;
                cnt_d   = instr_cnt + CNT_W'(1);
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                flags_d = bus.dp_flags;
                if (pc == PC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc + ADDR_W'(1);
                    state_d = step_en ? ST_PAUSE : ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (!step_en || step_rise) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                op_d    = HALT_CODE;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                 (state_d == ST_ISSUE) || (state_d == ST_LATCH)  ||
                 (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    // Registered outputs and the step edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            instr_cnt <= '0;
            op_q      <= HALT_CODE;
            flags_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            pc        <= pc_d;
            instr_cnt <= cnt_d;
            op_q      <= op_d;
            flags_q   <= flags_d;
            busy      <= busy_d;
            done      <= done_d;
            step_q    <= step;
        end
    end

endmodule
